// File: rtl/preif_pc_gen_pkg.sv
// preif_pc_gen_pkg: shared CPU fetch types and constants
package preif_pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          EPOCH_MAX_W      = 8;

    typedef enum logic {RUN, ERR} pc_state_t;

    // epoch field is sized for the widest supported tag; narrower tags are zero-extended
    typedef struct packed {
        logic [31:0]            pc;
        logic [EPOCH_MAX_W-1:0] epoch;
    } FetchQEntry_t;

endpackage

// File: rtl/preif_pc_gen_if.sv
// preif_pc_gen_if: redirect, I$ request/response and status bus of the PC generator
interface preif_pc_gen_if #(parameter int NUM_REDIRECT = 4);

    logic                         hold;
    logic [NUM_REDIRECT-1:0]      redirect_valid;
    logic [NUM_REDIRECT-1:0][31:0] redirect_pc;
    logic                         bpu_valid;
    logic [31:0]                  bpu_target;
    logic                         req_valid;
    logic [31:0]                  req_pc;
    logic                         req_ready;
    logic                         resp_valid;
    logic                         fetch_valid;
    logic [31:0]                  fetch_pc;
    logic                         err_valid;
    logic [31:0]                  err_pc;
    logic                         proto_err;

    modport master (
        input  hold, redirect_valid, redirect_pc, bpu_valid, bpu_target, req_ready, resp_valid,
        output req_valid, req_pc, fetch_valid, fetch_pc, err_valid, err_pc, proto_err
    );

    modport slave (
        output hold, redirect_valid, redirect_pc, bpu_valid, bpu_target, req_ready, resp_valid,
        input  req_valid, req_pc, fetch_valid, fetch_pc, err_valid, err_pc, proto_err
    );

endinterface

// File: rtl/preif_req_fifo.sv
// preif_req_fifo: outstanding fetch-request queue, head visible combinationally
module preif_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = count == CNT_W'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/preif_pc_gen.sv
// preif_pc_gen: next-fetch PC generation with redirect priority, epochs and response filtering
module preif_pc_gen
    import preif_pc_gen_pkg::*;
#(
    parameter int          NUM_REDIRECT = 4,
    parameter int          FETCH_WORDS  = 2,
    parameter int          QDEPTH       = 4,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          EPOCH_W      = 2
) (
    input logic            clk,
    input logic            rst,
    preif_pc_gen_if.master bus
);

    localparam logic [31:0] BLK   = 32'(4 * FETCH_WORDS);
    localparam int          CNT_W = $clog2(QDEPTH + 1);

    pc_state_t          state, state_d;
    logic [31:0]        pc, pc_d, err_pc, err_pc_d, win_pc;
    logic [EPOCH_W-1:0] epoch, epoch_d;
    logic               err_valid_q, err_valid_d, proto_err, proto_err_d;
    logic               any_redirect, misaligned, fire, pop, q_full, q_empty;
    logic [CNT_W-1:0]   q_count;
    FetchQEntry_t       push_entry, head;

    assign any_redirect    = |bus.redirect_valid;
    assign misaligned      = win_pc[1:0] != 2'b00;
    assign bus.req_valid   = !rst && state == RUN && !bus.hold && !q_full && !any_redirect;
    assign bus.req_pc      = pc;
    assign fire            = bus.req_valid && bus.req_ready;
    assign pop             = bus.resp_valid && q_count != '0;
    assign push_entry      = '{pc: pc, epoch: EPOCH_MAX_W'(epoch)};
    // a same-cycle redirect only bumps the registered epoch at the edge, so this sees the old one
    assign bus.fetch_valid = !rst && pop && head.epoch == EPOCH_MAX_W'(epoch);
    assign bus.fetch_pc    = head.pc;
    assign bus.err_valid   = !rst && err_valid_q;
    assign bus.err_pc      = err_pc;
    assign bus.proto_err   = proto_err;

    preif_req_fifo #(.DEPTH(QDEPTH), .WIDTH($bits(FetchQEntry_t))) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fire),
        .push_data(push_entry),
        .pop      (pop),
        .pop_data (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    // scanning downwards lets the lowest asserted index overwrite the rest
    always_comb begin
        win_pc = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--)
            if (bus.redirect_valid[i]) win_pc = bus.redirect_pc[i];
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        epoch_d     = epoch;
        err_valid_d = 1'b0;
        err_pc_d    = err_pc;
        proto_err_d = proto_err || (bus.resp_valid && q_empty);
        if (any_redirect) begin
            state_d     = misaligned ? ERR : RUN;
            pc_d        = win_pc;
            epoch_d     = epoch + 1'b1;
            err_valid_d = misaligned;
            err_pc_d    = misaligned ? win_pc : err_pc;
        end else if (fire) begin
            pc_d = bus.bpu_valid ? bus.bpu_target : (pc & ~(BLK - 32'd1)) + BLK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            epoch       <= '0;
            err_valid_q <= 1'b0;
            err_pc      <= '0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            epoch       <= epoch_d;
            err_valid_q <= err_valid_d;
            err_pc      <= err_pc_d;
            proto_err   <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_preif_pc_gen.sv
// tb_preif_pc_gen: scoreboard bench with a queue-based fetch model and randomized traffic
module tb_preif_pc_gen;
    import preif_pc_gen_pkg::*;

    localparam int          NR  = 4;
    localparam int          FW  = 2;
    localparam int          QD  = 4;
    localparam int          EW  = 2;
    localparam logic [31:0] BLK = 32'(4 * FW);

    typedef struct {
        logic [31:0] pc;
        int          epoch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    preif_pc_gen_if #(.NUM_REDIRECT(NR)) bus ();

    preif_pc_gen #(
        .NUM_REDIRECT(NR), .FETCH_WORDS(FW), .QDEPTH(QD),
        .RESET_PC(RESET_PC_DEFAULT), .EPOCH_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_err, m_proto, m_rv_exp, e_err_valid;
    logic [31:0] e_err_pc;
    logic        s_req_valid, s_err_valid, s_proto, s_fetch_valid;
    logic [31:0] s_req_pc, s_err_pc, s_fetch_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every response consumes the oldest outstanding request of the model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("fetch_valid_empty_q", bus.fetch_valid, 0);
                    m_proto = 1'b1;
                end else begin
                    exp_t e;
                    bit   fv;
                    e  = exp_q.pop_front();
                    fv = e.epoch == m_epoch;
                    chk("fetch_valid", bus.fetch_valid, fv);
                    if (fv) chk("fetch_pc", bus.fetch_pc, e.pc);
                end
                s_fetch_valid = bus.fetch_valid;
                s_fetch_pc    = bus.fetch_pc;
            end else begin
                chk("fetch_valid_idle", bus.fetch_valid, 0);
            end
        end
    end

    // called just after a posedge: drive, check settled outputs, then advance the model at the edge
    task automatic cycle(input logic h, input logic [NR-1:0] rv, input logic [NR-1:0][31:0] rp,
                         input logic bv, input logic [31:0] bt, input logic rdy, input logic rsp);
        int win;
        bus.hold           = h;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.bpu_valid      = bv;
        bus.bpu_target     = bt;
        bus.req_ready      = rdy;
        bus.resp_valid     = rsp;
        #3;
        m_rv_exp    = !m_err && !h && exp_q.size() < QD && rv == '0;
        s_req_valid = bus.req_valid;
        s_req_pc    = bus.req_pc;
        s_err_valid = bus.err_valid;
        s_err_pc    = bus.err_pc;
        s_proto     = bus.proto_err;
        chk("req_valid", bus.req_valid, m_rv_exp);
        if (m_rv_exp) chk("req_pc", bus.req_pc, m_pc);
        chk("err_valid", bus.err_valid, e_err_valid);
        if (e_err_valid) chk("err_pc", bus.err_pc, e_err_pc);
        chk("proto_err", bus.proto_err, m_proto);
        @(posedge clk);
        if (rv != '0) begin
            win = 0;
            for (int i = 0; i < NR; i++) if (rv[i]) begin win = i; break; end
            m_pc        = rp[win];
            m_epoch     = (m_epoch + 1) % (1 << EW);
            m_err       = rp[win][1:0] != 2'b00;
            e_err_valid = m_err;
            if (m_err) e_err_pc = rp[win];
        end else begin
            e_err_valid = 1'b0;
            if (m_rv_exp && rdy) begin
                exp_q.push_back('{pc: m_pc, epoch: m_epoch});
                m_pc = bv ? bt : (m_pc / BLK) * BLK + BLK;
            end
        end
        #1;
    endtask

    task automatic step(input logic rdy, input logic rsp);
        cycle(1'b0, '0, '0, 1'b0, '0, rdy, rsp);
    endtask

    task automatic redir(input int idx, input logic [31:0] pc);
        logic [NR-1:0]       rv;
        logic [NR-1:0][31:0] rp;
        rv      = '0;
        rp      = '0;
        rv[idx] = 1'b1;
        rp[idx] = pc;
        cycle(1'b0, rv, rp, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // outputs are checked while rst is high with a response pending, then the model restarts
    task automatic do_reset();
        rst                = 1'b1;
        bus.hold           = 1'b0;
        bus.redirect_valid = '0;
        bus.redirect_pc    = '0;
        bus.bpu_valid      = 1'b0;
        bus.bpu_target     = '0;
        bus.req_ready      = 1'b1;
        bus.resp_valid     = 1'b1;
        repeat (2) begin
            #3;
            chk("rst_req_valid", bus.req_valid, 0);
            chk("rst_fetch_valid", bus.fetch_valid, 0);
            chk("rst_err_valid", bus.err_valid, 0);
            @(posedge clk);
            #1;
        end
        rst            = 1'b0;
        bus.resp_valid = 1'b0;
        exp_q.delete();
        m_pc        = RESET_PC_DEFAULT;
        m_epoch     = 0;
        m_err       = 1'b0;
        m_proto     = 1'b0;
        e_err_valid = 1'b0;
        e_err_pc    = '0;
        chk("rst_err_pc", bus.err_pc, 0);
        chk("rst_proto_err", bus.proto_err, 0);
    endtask

    initial begin
        logic [NR-1:0][31:0] rp;
        @(posedge clk);
        #1;
        do_reset();

        // sequential block addresses after reset
        step(1, 0); chk("seq_pc0", s_req_pc, 32'hBFC00000);
        step(1, 0); chk("seq_pc1", s_req_pc, 32'hBFC00008);
        step(1, 0); chk("seq_pc2", s_req_pc, 32'hBFC00010);

        // two simultaneous redirects: index 1 beats index 3
        rp    = '0;
        rp[1] = 32'h80001000;
        rp[3] = 32'h80002000;
        cycle(0, 4'b1010, rp, 0, '0, 1, 0);
        chk("redir_no_fire", s_req_valid, 0);
        step(0, 0); chk("redir_pc", s_req_pc, 32'h80001000);

        // queue full blocks requests, one response frees a slot
        do_reset();
        repeat (4) step(1, 0);
        step(0, 0); chk("full_req_valid", s_req_valid, 0);
        step(0, 1); chk("full_oldest_pc", s_fetch_pc, 32'hBFC00000);
        step(0, 0); chk("unfull_req_valid", s_req_valid, 1);

        // stale-epoch responses dropped, post-redirect response passed
        do_reset();
        repeat (2) step(1, 0);
        redir(0, 32'h80004000);
        step(0, 1); chk("stale0", s_fetch_valid, 0);
        step(0, 1); chk("stale1", s_fetch_valid, 0);
        step(1, 0);
        step(0, 1); chk("fresh_valid", s_fetch_valid, 1);
        chk("fresh_pc", s_fetch_pc, 32'h80004000);

        // misaligned redirect reports once and stalls until an aligned redirect
        redir(2, 32'h80000002);
        step(1, 0); chk("err_pulse", s_err_valid, 1);
        chk("err_target", s_err_pc, 32'h80000002);
        chk("err_no_req", s_req_valid, 0);
        step(1, 0); chk("err_one_cycle", s_err_valid, 0);
        chk("err_still_stalled", s_req_valid, 0);
        redir(1, 32'h80000000);
        step(1, 0); chk("resume_valid", s_req_valid, 1);
        chk("resume_pc", s_req_pc, 32'h80000000);

        // response with nothing outstanding sets the sticky protocol flag
        do_reset();
        step(0, 1);
        step(0, 0); chk("proto_set", s_proto, 1);
        repeat (3) step(1, 0);
        chk("proto_sticky", s_proto, 1);
        do_reset();
        step(0, 0); chk("proto_cleared", s_proto, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [NR-1:0] rv;
            logic [31:0]   r;
            if ($urandom_range(0, 299) == 0) do_reset();
            rv = ($urandom_range(0, 9) == 0) ? NR'($urandom()) : '0;
            for (int i = 0; i < NR; i++) begin
                r = $urandom();
                r[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
                rp[i] = r;
            end
            cycle($urandom_range(0, 4) == 0, rv, rp, $urandom_range(0, 4) == 0, $urandom(),
                  $urandom_range(0, 9) < 7,
                  exp_q.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
